// File: rtl/snn_core_gen2.sv
// Two-layer fully-connected inference core (input -> hidden -> output) with argmax readout.
// Streams inputs and weights from external 1-cycle-latency memories, maps each
// accumulated sum through an external activation LUT and tracks the winning class.
module snn_core_gen2 #(
  parameter int unsigned N_IN  = 784,
  parameter int unsigned N_HID = 32,
  parameter int unsigned N_OUT = 10,
  parameter int unsigned IN_W  = 1,
  parameter int unsigned ACC_W = 26
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             abort,
  output logic [$clog2(N_IN)-1:0]          in_addr,
  input  logic [IN_W-1:0]                  in_data,
  output logic [$clog2(N_IN*N_HID)-1:0]    wh_addr,
  input  logic [7:0]                       wh_data,
  output logic [$clog2(N_HID*N_OUT)-1:0]   wo_addr,
  input  logic [7:0]                       wo_data,
  output logic [10:0]                      act_addr,
  input  logic [7:0]                       act_data,
  output logic                             busy,
  output logic                             done,
  output logic [$clog2(N_OUT)-1:0]         digit,
  output logic [7:0]                       max_act,
  output logic                             sat
);

  localparam int unsigned IN_AW  = $clog2(N_IN);
  localparam int unsigned WH_AW  = $clog2(N_IN*N_HID);
  localparam int unsigned WO_AW  = $clog2(N_HID*N_OUT);
  localparam int unsigned DG_W   = $clog2(N_OUT);
  localparam int unsigned HID_AW = $clog2(N_HID);
  localparam int unsigned CNT_W  = $clog2(((N_IN > N_HID) ? N_IN : N_HID) + 1);
  localparam int unsigned UNIT_W = $clog2(((N_HID > N_OUT) ? N_HID : N_OUT) + 1);

  localparam logic signed [ACC_W-1:0] S_HI = ACC_W'(1023);
  localparam logic signed [ACC_W-1:0] S_LO = ACC_W'(-1024);

  typedef enum logic [3:0] {
    S_IDLE, S_H_MAC, S_H_DRAIN, S_H_ACT, S_H_WR,
    S_O_MAC, S_O_DRAIN, S_O_ACT, S_O_WR, S_DONE
  } state_t;

  state_t                   r_state;
  state_t                   w_next;

  logic [CNT_W-1:0]         r_idx;
  logic [UNIT_W-1:0]        r_unit;
  logic signed [ACC_W-1:0]  r_acc;
  logic signed [7:0]        r_hid [N_HID];
  logic signed [7:0]        r_hid_q;
  logic signed [7:0]        r_max;
  logic [DG_W-1:0]          r_arg;
  logic                     r_sat_run;

  logic [IN_AW-1:0]         r_in_addr;
  logic [WH_AW-1:0]         r_wh_addr;
  logic [WO_AW-1:0]         r_wo_addr;
  logic [10:0]              r_act_addr;
  logic                     r_busy;
  logic                     r_done;
  logic [DG_W-1:0]          r_digit;
  logic [7:0]               r_max_act;
  logic                     r_sat;

  logic                     w_busy_nxt;
  logic                     w_done_nxt;
  logic                     w_hid_layer;
  logic                     w_mac_en;
  logic signed [7:0]        w_in_a;
  logic signed [7:0]        w_a;
  logic signed [7:0]        w_b;
  logic signed [15:0]       w_prod;
  logic signed [ACC_W-1:0]  w_acc_sum;
  logic signed [ACC_W-1:0]  w_s;
  logic [10:0]              w_lut_addr;
  logic                     w_clamp;
  logic signed [7:0]        w_act;
  logic                     w_better;
  logic                     w_idx_last_in;
  logic                     w_idx_last_hid;
  logic                     w_unit_last_hid;
  logic                     w_unit_last_out;

  // Binary inputs become a full-scale positive activation; byte inputs are used as signed values
  if (IN_W == 1) begin : g_in_bin
    assign w_in_a = in_data[0] ? 8'sh7F : 8'sh00;
  end else begin : g_in_byte
    assign w_in_a = in_data[7:0];
  end

  assign w_idx_last_in   = (r_idx == CNT_W'(N_IN - 1));
  assign w_idx_last_hid  = (r_idx == CNT_W'(N_HID - 1));
  assign w_unit_last_hid = (r_unit == UNIT_W'(N_HID - 1));
  assign w_unit_last_out = (r_unit == UNIT_W'(N_OUT - 1));

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  // Next-state logic; abort cancels any running state except the final DONE
  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = S_H_MAC;
      S_H_MAC:   if (w_idx_last_in) w_next = S_H_DRAIN;
      S_H_DRAIN: w_next = S_H_ACT;
      S_H_ACT:   w_next = S_H_WR;
      S_H_WR:    w_next = w_unit_last_hid ? S_O_MAC : S_H_MAC;
      S_O_MAC:   if (w_idx_last_hid) w_next = S_O_DRAIN;
      S_O_DRAIN: w_next = S_O_ACT;
      S_O_ACT:   w_next = S_O_WR;
      S_O_WR:    w_next = w_unit_last_out ? S_DONE : S_O_MAC;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
    if (abort && (r_state != S_IDLE) && (r_state != S_DONE)) w_next = S_IDLE;
  end

  // State-derived controls for the datapath and registered status outputs
  always_comb begin
    w_busy_nxt  = (w_next != S_IDLE);
    w_done_nxt  = (w_next == S_DONE);
    w_hid_layer = (r_state == S_H_MAC) || (r_state == S_H_DRAIN);
    w_mac_en    = (((r_state == S_H_MAC) || (r_state == S_O_MAC)) && (r_idx != '0)) ||
                  (r_state == S_H_DRAIN) || (r_state == S_O_DRAIN);
  end

  // MAC, LUT index clamp and running-max compare
  always_comb begin
    w_a       = w_hid_layer ? w_in_a  : r_hid_q;
    w_b       = w_hid_layer ? wh_data : wo_data;
    w_prod    = 16'(w_a) * 16'(w_b);
    w_acc_sum = r_acc + ACC_W'(w_prod);
    w_s       = w_acc_sum >>> 7;
    w_clamp   = 1'b0;
    if (w_s > S_HI) begin
      w_lut_addr = 11'd2047;
      w_clamp    = 1'b1;
    end else if (w_s < S_LO) begin
      w_lut_addr = 11'd0;
      w_clamp    = 1'b1;
    end else begin
      w_lut_addr = {~w_s[10], w_s[9:0]};
    end
    w_act    = act_data;
    w_better = (r_unit == '0) || (w_act > r_max);
  end

  // Datapath, address generators and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idx      <= '0;
      r_unit     <= '0;
      r_acc      <= '0;
      r_hid_q    <= '0;
      r_max      <= '0;
      r_arg      <= '0;
      r_sat_run  <= 1'b0;
      r_in_addr  <= '0;
      r_wh_addr  <= '0;
      r_wo_addr  <= '0;
      r_act_addr <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_digit    <= '0;
      r_max_act  <= '0;
      r_sat      <= 1'b0;
      for (int k = 0; k < N_HID; k++) r_hid[k] <= '0;
    end else begin
      r_busy <= w_busy_nxt;
      r_done <= w_done_nxt;
      if (w_mac_en) r_acc <= w_acc_sum;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_acc     <= '0;
            r_idx     <= '0;
            r_unit    <= '0;
            r_max     <= '0;
            r_arg     <= '0;
            r_sat_run <= 1'b0;
            r_in_addr <= '0;
            r_wh_addr <= '0;
          end
        end
        S_H_MAC: begin
          if (!w_idx_last_in) begin
            r_idx     <= r_idx + CNT_W'(1);
            r_in_addr <= r_in_addr + IN_AW'(1);
            r_wh_addr <= r_wh_addr + WH_AW'(1);
          end
        end
        S_H_DRAIN, S_O_DRAIN: begin
          r_act_addr <= w_lut_addr;
          if (w_clamp) r_sat_run <= 1'b1;
        end
        S_H_WR: begin
          r_hid[r_unit[HID_AW-1:0]] <= act_data;
          r_acc <= '0;
          r_idx <= '0;
          if (w_unit_last_hid) begin
            r_unit    <= '0;
            r_wo_addr <= '0;
          end else begin
            r_unit    <= r_unit + UNIT_W'(1);
            r_in_addr <= '0;
            r_wh_addr <= r_wh_addr + WH_AW'(1);
          end
        end
        S_O_MAC: begin
          r_hid_q <= r_hid[r_idx[HID_AW-1:0]];
          if (!w_idx_last_hid) begin
            r_idx     <= r_idx + CNT_W'(1);
            r_wo_addr <= r_wo_addr + WO_AW'(1);
          end
        end
        S_O_WR: begin
          r_acc <= '0;
          r_idx <= '0;
          if (w_better) begin
            r_max <= w_act;
            r_arg <= r_unit[DG_W-1:0];
          end
          if (!w_unit_last_out) begin
            r_unit    <= r_unit + UNIT_W'(1);
            r_wo_addr <= r_wo_addr + WO_AW'(1);
          end
          if (w_next == S_DONE) begin
            r_digit   <= w_better ? r_unit[DG_W-1:0] : r_arg;
            r_max_act <= w_better ? w_act : r_max;
            r_sat     <= r_sat_run;
          end
        end
        default: ;
      endcase
    end
  end

  assign in_addr  = r_in_addr;
  assign wh_addr  = r_wh_addr;
  assign wo_addr  = r_wo_addr;
  assign act_addr = r_act_addr;
  assign busy     = r_busy;
  assign done     = r_done;
  assign digit    = r_digit;
  assign max_act  = r_max_act;
  assign sat      = r_sat;

endmodule

// File: tb/tb_snn_core_gen2.sv
// Directed bench: a full-size core (binary inputs) and a 4-2-3 core driven by small memories.
module tb_snn_core_gen2;

  logic clk;
  logic rst_n;

  // Full-size instance
  logic        b_start, b_abort;
  logic [9:0]  b_in_addr;
  logic        b_in_data;
  logic [14:0] b_wh_addr;
  logic [7:0]  b_wh_data;
  logic [8:0]  b_wo_addr;
  logic [7:0]  b_wo_data;
  logic [10:0] b_act_addr;
  logic [7:0]  b_act_data;
  logic        b_busy, b_done, b_sat;
  logic [3:0]  b_digit;
  logic [7:0]  b_max_act;
  logic        b_in_val;
  logic [7:0]  b_wh_val;

  // Small instance
  logic        s_start, s_abort;
  logic [1:0]  s_in_addr;
  logic        s_in_data;
  logic [2:0]  s_wh_addr;
  logic [7:0]  s_wh_data;
  logic [2:0]  s_wo_addr;
  logic [7:0]  s_wo_data;
  logic [10:0] s_act_addr;
  logic [7:0]  s_act_data;
  logic        s_busy, s_done, s_sat;
  logic [1:0]  s_digit;
  logic [7:0]  s_max_act;
  logic        s_mem_in [4];
  logic [7:0]  s_mem_wh [8];
  logic [7:0]  s_mem_wo [6];

  int n_total = 0;
  int n_bad   = 0;

  snn_core_gen2 u_big (
    .clk(clk), .rst_n(rst_n), .start(b_start), .abort(b_abort),
    .in_addr(b_in_addr), .in_data(b_in_data),
    .wh_addr(b_wh_addr), .wh_data(b_wh_data),
    .wo_addr(b_wo_addr), .wo_data(b_wo_data),
    .act_addr(b_act_addr), .act_data(b_act_data),
    .busy(b_busy), .done(b_done), .digit(b_digit), .max_act(b_max_act), .sat(b_sat)
  );

  snn_core_gen2 #(.N_IN(4), .N_HID(2), .N_OUT(3), .IN_W(1), .ACC_W(26)) u_small (
    .clk(clk), .rst_n(rst_n), .start(s_start), .abort(s_abort),
    .in_addr(s_in_addr), .in_data(s_in_data),
    .wh_addr(s_wh_addr), .wh_data(s_wh_data),
    .wo_addr(s_wo_addr), .wo_data(s_wo_data),
    .act_addr(s_act_addr), .act_data(s_act_data),
    .busy(s_busy), .done(s_done), .digit(s_digit), .max_act(s_max_act), .sat(s_sat)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memories with one cycle of read latency; LUT value is (addr-1024)[7:0] == addr[7:0]
  always @(posedge clk) begin
    b_in_data  <= b_in_val;
    b_wh_data  <= b_wh_val;
    b_wo_data  <= 8'h00;
    b_act_data <= b_act_addr[7:0];
    s_in_data  <= s_mem_in[s_in_addr];
    s_wh_data  <= s_mem_wh[s_wh_addr];
    s_wo_data  <= s_mem_wo[s_wo_addr];
    s_act_data <= s_act_addr[7:0];
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Pattern 1: hid=[3,3], only class 2 weighted -> class 2 act 5
  // Pattern 2: class 0 negative (-6), classes 1/2 tie at 5 -> class 1
  // Pattern 3: inputs 1010, hid=[127,-127], outputs 126/-4/-127 -> class 0
  task automatic load_pat(input int p);
    for (int i = 0; i < 4; i++) s_mem_in[i] = 1'b1;
    for (int i = 0; i < 8; i++) s_mem_wh[i] = 8'h01;
    for (int i = 0; i < 6; i++) s_mem_wo[i] = 8'h00;
    case (p)
      1: begin
        s_mem_wo[4] = 8'h7F; s_mem_wo[5] = 8'h7F;
      end
      2: begin
        s_mem_wo[0] = 8'h81; s_mem_wo[1] = 8'h81;
        s_mem_wo[2] = 8'h7F; s_mem_wo[3] = 8'h7F;
        s_mem_wo[4] = 8'h7F; s_mem_wo[5] = 8'h7F;
      end
      default: begin
        s_mem_in[1] = 1'b0; s_mem_in[3] = 1'b0;
        for (int i = 0; i < 4; i++) s_mem_wh[i] = 8'h40;
        for (int i = 4; i < 8; i++) s_mem_wh[i] = 8'hC0;
        s_mem_wo[0] = 8'h7F; s_mem_wo[1] = 8'h00;
        s_mem_wo[2] = 8'h7F; s_mem_wo[3] = 8'h81;
        s_mem_wo[4] = 8'h00; s_mem_wo[5] = 8'h7F;
      end
    endcase
  endtask

  task automatic big_run(input string tag, input logic [10:0] exp_act, input logic exp_sat);
    int cnt;
    bit seen;
    @(negedge clk); b_start = 1'b1;
    @(posedge clk); #1 b_start = 1'b0;
    check({tag, " busy"}, 32'(b_busy), 32'd1);
    cnt = 0; seen = 0;
    while (!seen && cnt < 26000) begin
      @(posedge clk); cnt++; #1;
      if (cnt == 1) begin
        check({tag, " in_addr1"}, 32'(b_in_addr), 32'd1);
        check({tag, " wh_addr1"}, 32'(b_wh_addr), 32'd1);
      end
      if (cnt == 785) check({tag, " act_addr"}, 32'(b_act_addr), 32'(exp_act));
      if (cnt == 788) check({tag, " wh_addr_u1"}, 32'(b_wh_addr), 32'd785);
      if (b_done) seen = 1;
    end
    check({tag, " latency"}, 32'(cnt), 32'd25534);
    check({tag, " digit"}, 32'(b_digit), 32'd0);
    check({tag, " max_act"}, 32'(b_max_act), 32'd0);
    check({tag, " sat"}, 32'(b_sat), 32'(exp_sat));
    check({tag, " wo_addr"}, 32'(b_wo_addr), 32'd319);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(b_done), 32'd0);
    check({tag, " busy_off"}, 32'(b_busy), 32'd0);
  endtask

  task automatic small_run(input string tag, input int exp_digit, input int exp_max, input bit with_abort);
    int cnt;
    bit seen;
    @(negedge clk); s_start = 1'b1; s_abort = with_abort;
    @(posedge clk); #1 s_start = 1'b0; s_abort = 1'b0;
    check({tag, " busy"}, 32'(s_busy), 32'd1);
    cnt = 0; seen = 0;
    while (!seen && cnt < 200) begin
      @(posedge clk); cnt++; #1;
      if (s_done) seen = 1;
    end
    check({tag, " latency"}, 32'(cnt), 32'd29);
    check({tag, " digit"}, 32'(s_digit), 32'(exp_digit));
    check({tag, " max_act"}, 32'(s_max_act), 32'(exp_max));
    check({tag, " sat"}, 32'(s_sat), 32'd0);
    @(posedge clk); #1;
    check({tag, " done_pulse"}, 32'(s_done), 32'd0);
    check({tag, " busy_off"}, 32'(s_busy), 32'd0);
  endtask

  initial begin
    int cnt;
    bit seen;
    rst_n = 1'b0;
    b_start = 1'b0; b_abort = 1'b0; b_in_val = 1'b0; b_wh_val = 8'h00;
    s_start = 1'b0; s_abort = 1'b0;
    load_pat(1);
    #12;
    check("rst busy", 32'(s_busy), 32'd0);
    check("rst done", 32'(s_done), 32'd0);
    check("rst digit", 32'(s_digit), 32'd0);
    check("rst max_act", 32'(s_max_act), 32'd0);
    check("rst sat", 32'(s_sat), 32'd0);
    check("rst addrs", {s_act_addr, s_wo_addr, s_wh_addr, s_in_addr}, 32'd0);
    check("rst big", {b_act_addr, b_digit, b_sat, b_busy}, 32'd0);
    @(negedge clk); rst_n = 1'b1;

    // Saturating hidden layer first, then an all-zero run must clear sat
    b_in_val = 1'b1; b_wh_val = 8'h7F;
    big_run("big_sat", 11'd2047, 1'b1);
    b_in_val = 1'b0; b_wh_val = 8'h00;
    big_run("big_zero", 11'd1024, 1'b0);

    load_pat(1); small_run("patA", 2, 8'h05, 1'b0);
    load_pat(2); small_run("patB", 1, 8'h05, 1'b0);
    load_pat(3); small_run("patC", 0, 8'h7E, 1'b0);

    // Abort inside the hidden MAC phase: no done, previous result retained
    load_pat(2);
    @(negedge clk); s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); s_abort = 1'b1;
    @(posedge clk); #1 s_abort = 1'b0;
    check("abort busy", 32'(s_busy), 32'd0);
    seen = 0;
    repeat (40) begin
      @(posedge clk); #1;
      if (s_done || s_busy) seen = 1;
    end
    check("abort quiet", 32'(seen), 32'd0);
    check("abort digit", 32'(s_digit), 32'd0);
    check("abort max_act", 32'(s_max_act), 32'h7E);

    // start and abort together in IDLE: start wins
    small_run("start_abort", 1, 8'h05, 1'b1);

    // start held high: done pulses spaced by run length plus DONE and IDLE cycles
    load_pat(1);
    @(negedge clk); s_start = 1'b1;
    for (int r = 0; r < 3; r++) begin
      cnt = 0; seen = 0;
      while (!seen && cnt < 200) begin
        @(posedge clk); cnt++; #1;
        if (s_done) seen = 1;
      end
      if (r == 0) check("b2b first", 32'(cnt), 32'd30);
      else        check("b2b spacing", 32'(cnt), 32'd31);
      check("b2b digit", 32'(s_digit), 32'd2);
    end
    s_start = 1'b0;
    repeat (2) @(posedge clk);
    #1 check("b2b idle", 32'(s_busy), 32'd0);

    // Asynchronous reset while in the output MAC phase
    load_pat(3);
    @(negedge clk); s_start = 1'b1;
    @(posedge clk); #1 s_start = 1'b0;
    repeat (15) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("midrst busy", 32'(s_busy), 32'd0);
    check("midrst digit", 32'(s_digit), 32'd0);
    check("midrst max_act", 32'(s_max_act), 32'd0);
    check("midrst addrs", {s_act_addr, s_wo_addr, s_wh_addr, s_in_addr}, 32'd0);
    @(negedge clk); rst_n = 1'b1;
    load_pat(2); small_run("post_rst", 1, 8'h05, 1'b0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
